// File: rtl/coffee_pkg.sv
// Shared types and reset-default recipe contents for the coffee recipe sequencer.
package coffee_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_T1   = 3'd1,
    C_T2   = 3'd2,
    C_T3   = 3'd3,
    C_T4   = 3'd4
  } coffee_t;

  // Factory recipe: duration in time units for type code t (1-based), ingredient i.
  function automatic logic [3:0] default_time(input int t, input int i);
    logic [3:0] r;
    r = 4'd0;
    case (t)
      int'(C_T1): case (i) 0: r = 4'd2; 1: r = 4'd3; 4: r = 4'd1; default: r = 4'd0; endcase
      int'(C_T2): case (i) 0: r = 4'd2; 1: r = 4'd2; 2: r = 4'd1; 4: r = 4'd1; default: r = 4'd0; endcase
      int'(C_T3): case (i) 0: r = 4'd2; 1: r = 4'd1; 2: r = 4'd2; 4: r = 4'd1; default: r = 4'd0; endcase
      int'(C_T4): case (i) 0: r = 4'd1; 1: r = 4'd1; 2: r = 4'd1; 3: r = 4'd2; 4: r = 4'd1; default: r = 4'd0; endcase
      default: r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that marks the last clock cycle of every time unit.
module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/recipe_sequencer.sv
// Steps through the selected recipe, opening each ingredient valve for its
// programmed number of time units; the recipe table is writable while idle.
module recipe_sequencer
  import coffee_pkg::*;
#(
  parameter int N_ING    = 5,
  parameter int N_TYPES  = 4,
  parameter int TYPE_W   = 3,
  parameter int T_W      = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [TYPE_W-1:0]          c_type,
  input  logic                       abort,
  input  logic                       cfg_we,
  input  logic [TYPE_W-1:0]          cfg_type,
  input  logic [$clog2(N_ING)-1:0]   cfg_ing,
  input  logic [T_W-1:0]             cfg_time,
  output logic                       busy,
  output logic [N_ING-1:0]           valve,
  output logic [$clog2(N_ING)-1:0]   cur_ing,
  output logic [T_W-1:0]             remaining,
  output logic                       done,
  output logic                       err,
  output logic                       aborted
);

  localparam int IW   = $clog2(N_ING);
  localparam int TI_W = (N_TYPES > 1) ? $clog2(N_TYPES) : 1;
  localparam logic [IW-1:0]    LAST_ING = IW'(N_ING - 1);
  localparam logic [N_ING-1:0] ONE_HOT  = N_ING'(1);

  state_t            state;
  logic [TI_W-1:0]   type_q;
  logic [T_W-1:0]    tbl [N_TYPES][N_ING];
  logic [T_W-1:0]    entry;
  logic              type_ok;
  logic              cfg_ok;
  logic [TI_W-1:0]   cfg_tidx;
  logic              presc_clr;
  logic              presc_en;
  logic              tick;

  assign type_ok  = (c_type != '0) && (int'(c_type) <= N_TYPES);
  assign cfg_ok   = cfg_we && (state == S_IDLE) && (cfg_type != '0) &&
                    (int'(cfg_type) <= N_TYPES) && (int'(cfg_ing) < N_ING);
  assign cfg_tidx = TI_W'(cfg_type - TYPE_W'(1));
  assign entry    = tbl[type_q][cur_ing];

  // Table lives in flops so a reset can restore the factory recipes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N_TYPES; t++) begin
        for (int i = 0; i < N_ING; i++) begin
          tbl[t][i] <= T_W'(default_time(t + 1, i));
        end
      end
    end else if (cfg_ok) begin
      tbl[cfg_tidx][cfg_ing] <= cfg_time;
    end
  end

  assign presc_clr = (state != S_RUN);
  assign presc_en  = (state == S_RUN);

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      type_q    <= '0;
      busy      <= 1'b0;
      valve     <= '0;
      cur_ing   <= '0;
      remaining <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        valve     <= '0;
        cur_ing   <= '0;
        remaining <= '0;
        aborted   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (type_ok) begin
                type_q  <= TI_W'(c_type - TYPE_W'(1));
                cur_ing <= '0;
                busy    <= 1'b1;
                state   <= S_LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (entry == '0) begin
              if (cur_ing == LAST_ING) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                cur_ing <= cur_ing + 1'b1;
              end
            end else begin
              remaining <= entry;
              valve     <= ONE_HOT << cur_ing;
              state     <= S_RUN;
            end
          end
          S_RUN: begin
            if (tick) begin
              remaining <= remaining - 1'b1;
              // Last unit of this ingredient: close valve on the same edge.
              if (remaining == T_W'(1)) begin
                valve <= '0;
                if (cur_ing == LAST_ING) begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  cur_ing <= cur_ing + 1'b1;
                  state   <= S_LOAD;
                end
              end
            end
          end
          S_DONE: begin
            busy      <= 1'b0;
            cur_ing   <= '0;
            remaining <= '0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recipe_sequencer.sv
// Directed bench for recipe_sequencer with TICK_DIV=4.
module tb_recipe_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] c_type = '0;
  logic       abort = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_type = '0;
  logic [2:0] cfg_ing = '0;
  logic [3:0] cfg_time = '0;
  logic       busy;
  logic [4:0] valve;
  logic [2:0] cur_ing;
  logic [3:0] remaining;
  logic       done;
  logic       err;
  logic       aborted;

  int tests = 0;
  int failed = 0;

  recipe_sequencer #(
    .N_ING(5), .N_TYPES(4), .TYPE_W(3), .T_W(4), .TICK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .c_type(c_type), .abort(abort),
    .cfg_we(cfg_we), .cfg_type(cfg_type), .cfg_ing(cfg_ing), .cfg_time(cfg_time),
    .busy(busy), .valve(valve), .cur_ing(cur_ing), .remaining(remaining),
    .done(done), .err(err), .aborted(aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one cycle (cycle 0); returns at the start of cycle 1.
  task automatic start_brew(input logic [2:0] t);
    start = 1'b1;
    c_type = t;
    next_cycle();
    start = 1'b0;
    c_type = '0;
  endtask

  task automatic cfg_write(input logic [2:0] t, input logic [2:0] i, input logic [3:0] v);
    cfg_we = 1'b1; cfg_type = t; cfg_ing = i; cfg_time = v;
    next_cycle();
    cfg_we = 1'b0; cfg_type = '0; cfg_ing = '0; cfg_time = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, valve, cur_ing, remaining, done, err, aborted} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got busy=%b valve=%b cur_ing=%0d rem=%0d done=%b err=%b aborted=%b, want all 0",
               busy, valve, cur_ing, remaining, done, err, aborted);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_t1_timeline();
    logic [4:0] ev;
    start_brew(3'd1);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 9)   ? 5'b00001 :
           (c >= 11 && c <= 22) ? 5'b00010 :
           (c >= 26 && c <= 29) ? 5'b10000 : 5'b00000;
      tests++;
      if (valve !== ev) begin failed++; $display("FAIL t1_valve c=%0d: got %b want %b", c, valve, ev); end
      tests++;
      if (done !== (c == 30)) begin failed++; $display("FAIL t1_done c=%0d: got %b want %b", c, done, (c == 30)); end
      tests++;
      if (busy !== (c <= 30)) begin failed++; $display("FAIL t1_busy c=%0d: got %b want %b", c, busy, (c <= 30)); end
      if (c == 2 || c == 6) begin
        tests++;
        if (remaining !== ((c == 2) ? 4'd2 : 4'd1)) begin
          failed++; $display("FAIL t1_remaining c=%0d: got %0d want %0d", c, remaining, (c == 2) ? 2 : 1);
        end
      end
      if (c == 23 || c == 24) begin
        tests++;
        if (cur_ing !== ((c == 23) ? 3'd2 : 3'd3)) begin
          failed++; $display("FAIL t1_skip_ing c=%0d: got %0d want %0d", c, cur_ing, c - 21);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_invalid_type();
    logic [2:0] bad [2];
    bad[0] = 3'd0;
    bad[1] = 3'd5;
    for (int k = 0; k < 2; k++) begin
      start_brew(bad[k]);
      @(negedge clk);
      tests++;
      if ({err, busy, valve} !== {1'b1, 1'b0, 5'b0}) begin
        failed++; $display("FAIL invalid_type_%0d: got err=%b busy=%b valve=%b want err=1 busy=0 valve=0", bad[k], err, busy, valve);
      end
      next_cycle();
      @(negedge clk);
      tests++;
      if ({err, busy, valve} !== 7'b0) begin
        failed++; $display("FAIL invalid_type_after_%0d: got err=%b busy=%b valve=%b want all 0", bad[k], err, busy, valve);
      end
      next_cycle();
    end
  endtask

  task automatic test_cfg_write();
    logic [4:0] ev;
    cfg_write(3'd2, 3'd3, 4'd3);
    start_brew(3'd2);
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 9)   ? 5'b00001 :
           (c >= 11 && c <= 18) ? 5'b00010 :
           (c >= 20 && c <= 23) ? 5'b00100 :
           (c >= 25 && c <= 36) ? 5'b01000 :
           (c >= 38 && c <= 41) ? 5'b10000 : 5'b00000;
      tests++;
      if (valve !== ev) begin failed++; $display("FAIL cfg_t2_valve c=%0d: got %b want %b", c, valve, ev); end
      tests++;
      if (done !== (c == 42)) begin failed++; $display("FAIL cfg_t2_done c=%0d: got %b want %b", c, done, (c == 42)); end
      next_cycle();
    end
  endtask

  task automatic test_abort();
    logic [4:0] ev;
    start_brew(3'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 5) ? 5'b00001 : (c == 7) ? 5'b00010 : 5'b00000;
      tests++;
      if (valve !== ev) begin failed++; $display("FAIL abort_pre_valve c=%0d: got %b want %b", c, valve, ev); end
      next_cycle();
    end
    abort = 1'b1;
    @(negedge clk);
    tests++;
    if (valve !== 5'b00010) begin failed++; $display("FAIL abort_cycle8_valve: got %b want 00010", valve); end
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    tests++;
    if ({valve, aborted, busy, done, remaining} !== {5'b0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      failed++; $display("FAIL abort_effect: got valve=%b aborted=%b busy=%b done=%b rem=%0d want valve=0 aborted=1 busy=0 done=0 rem=0",
                         valve, aborted, busy, done, remaining);
    end
    next_cycle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests++;
      if ({aborted, busy, done, valve} !== 8'b0) begin
        failed++; $display("FAIL abort_quiet c=%0d: got aborted=%b busy=%b done=%b valve=%b want all 0", c, aborted, busy, done, valve);
      end
      next_cycle();
    end
    start_brew(3'd4);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 5)   ? 5'b00001 :
           (c >= 7 && c <= 10)  ? 5'b00010 :
           (c >= 12 && c <= 15) ? 5'b00100 :
           (c >= 17 && c <= 24) ? 5'b01000 :
           (c >= 26 && c <= 29) ? 5'b10000 : 5'b00000;
      tests++;
      if (valve !== ev) begin failed++; $display("FAIL abort_restart_valve c=%0d: got %b want %b", c, valve, ev); end
      tests++;
      if (done !== (c == 30)) begin failed++; $display("FAIL abort_restart_done c=%0d: got %b want %b", c, done, (c == 30)); end
      next_cycle();
    end
  endtask

  task automatic test_busy_ignores();
    logic [4:0] ev;
    int n_done;
    int n_v2;
    n_done = 0;
    start_brew(3'd3);
    for (int c = 1; c <= 35; c++) begin
      if (c == 12) begin
        cfg_we = 1'b1; cfg_type = 3'd3; cfg_ing = 3'd2; cfg_time = 4'd7;
        start = 1'b1; c_type = 3'd1;
      end
      if (c == 13) begin
        cfg_we = 1'b0; cfg_type = '0; cfg_ing = '0; cfg_time = '0;
        start = 1'b0; c_type = '0;
      end
      @(negedge clk);
      ev = (c >= 2 && c <= 9)   ? 5'b00001 :
           (c >= 11 && c <= 14) ? 5'b00010 :
           (c >= 16 && c <= 23) ? 5'b00100 :
           (c >= 26 && c <= 29) ? 5'b10000 : 5'b00000;
      tests++;
      if (valve !== ev) begin failed++; $display("FAIL busy_t3_valve c=%0d: got %b want %b", c, valve, ev); end
      tests++;
      if (err !== 1'b0) begin failed++; $display("FAIL busy_t3_err c=%0d: got %b want 0", c, err); end
      if (done === 1'b1) n_done++;
      next_cycle();
    end
    tests++;
    if (n_done !== 1) begin failed++; $display("FAIL busy_t3_done_count: got %0d want 1", n_done); end
    n_done = 0;
    n_v2 = 0;
    start_brew(3'd3);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (valve[2] === 1'b1) n_v2++;
      if (done === 1'b1) n_done++;
      next_cycle();
    end
    tests++;
    if (n_v2 !== 8) begin failed++; $display("FAIL busy_table_unchanged: valve[2] cycles got %0d want 8", n_v2); end
    tests++;
    if (n_done !== 1) begin failed++; $display("FAIL busy_rerun_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_zero_and_reset();
    logic [4:0] ev;
    for (int i = 0; i < 5; i++) cfg_write(3'd1, 3'(i), 4'd0);
    start_brew(3'd1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      tests++;
      if (valve !== 5'b0) begin failed++; $display("FAIL zero_valve c=%0d: got %b want 00000", c, valve); end
      tests++;
      if (done !== (c == 6)) begin failed++; $display("FAIL zero_done c=%0d: got %b want %b", c, done, (c == 6)); end
      tests++;
      if (busy !== (c <= 6)) begin failed++; $display("FAIL zero_busy c=%0d: got %b want %b", c, busy, (c <= 6)); end
      if (c <= 5) begin
        tests++;
        if (cur_ing !== 3'(c - 1)) begin failed++; $display("FAIL zero_cur_ing c=%0d: got %0d want %0d", c, cur_ing, c - 1); end
      end
      next_cycle();
    end
    start_brew(3'd2);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests++;
    if (valve !== 5'b00001) begin failed++; $display("FAIL rst_pre_valve: got %b want 00001", valve); end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, valve, cur_ing, remaining, done, err, aborted} !== '0) begin
      failed++; $display("FAIL rst_async: got busy=%b valve=%b cur_ing=%0d rem=%0d done=%b want all 0",
                         busy, valve, cur_ing, remaining, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    next_cycle();
    start_brew(3'd1);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 9)   ? 5'b00001 :
           (c >= 11 && c <= 22) ? 5'b00010 :
           (c >= 26 && c <= 29) ? 5'b10000 : 5'b00000;
      tests++;
      if (valve !== ev) begin failed++; $display("FAIL rst_default_t1_valve c=%0d: got %b want %b", c, valve, ev); end
      tests++;
      if (done !== (c == 30)) begin failed++; $display("FAIL rst_default_t1_done c=%0d: got %b want %b", c, done, (c == 30)); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_t1_timeline();
    test_invalid_type();
    test_cfg_write();
    test_abort();
    test_busy_ignores();
    test_zero_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
